fxfl_stream_conv: RTL and testbench



---
 rtl/fxfl_pkg.sv | 39 +++
 rtl/fxfl_cvt_pipe.sv | 151 +++++++++++++++
 rtl/fxfl_stream_conv.sv | 77 +++++++
 tb/tb_fxfl_stream_conv.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxfl_pkg.sv
// Shared encodings, word layout and float constants for the float32 <-> fixed stream converter.
package fxfl_pkg;

   localparam logic [1:0] OP_F2X = 2'b00;
   localparam logic [1:0] OP_X2F = 2'b01;

   localparam int OP_HI    = 47;
   localparam int OP_LO    = 46;
   localparam int SAT_BIT  = 45;
   localparam int INEX_BIT = 44;
   localparam int RES_W    = 40;

   localparam int          F_BIAS     = 127;
   localparam int          F_MANT_W   = 23;
   localparam logic [7:0]  F_EXP_ONES = 8'hFF;

   typedef enum logic [2:0] {
      K_F2X, K_X2F, K_ZERO, K_SAT, K_NAN, K_RSVD
   } kind_e;

   // Unpacked operand handed from the shift stage to the round/pack stage.
   typedef struct packed {
      logic [1:0]  op;
      kind_e       kind;
      logic        sign;
      logic        ovf;
      logic [40:0] mag;
      logic [7:0]  exp;
      logic        guard;
      logic        sticky;
   } stage_t;

   function automatic logic [RES_W-1:0] fx_limit(input int fx_w, input logic neg);
      logic [RES_W:0] one;
      one = (RES_W+1)'(1) << (fx_w - 1);
      fx_limit = neg ? RES_W'(-one) : RES_W'(one - (RES_W+1)'(1));
   endfunction

endpackage

// File: rtl/fxfl_cvt_pipe.sv
// Fixed-latency conversion datapath: S0 captures the word, S1 unpacks and shifts,
// S2 rounds and packs combinationally into the output buffer write port.
module fxfl_cvt_pipe
   import fxfl_pkg::*;
#(
   parameter int INT_W  = 16,
   parameter int FRAC_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [47:0] in_word,
   output logic        out_valid,
   output logic [47:0] out_word,
   output logic [1:0]  stage_cnt
);

   localparam int FX_W = INT_W + FRAC_W;
   localparam logic [41:0] POS_LIM = (42'd1 << (FX_W - 1)) - 42'd1;
   localparam logic [41:0] NEG_LIM = 42'd1 << (FX_W - 1);

   logic        v0, v1;
   logic [47:0] s0_word;
   stage_t      s1_next, s1;

   logic [7:0]        e;
   logic [23:0]       m24;
   logic signed [9:0] sh;
   logic [9:0]        nsh;
   logic [5:0]        rs;
   logic [49:0]       rwide;
   logic [63:0]       lwide;
   logic [40:0]       xe, xabs, norm;
   logic [5:0]        msb;

   logic              rnd, sat, inex;
   logic [41:0]       mag_r;
   logic [24:0]       mant_r;
   logic [RES_W-1:0]  res;
   logic              unused_bits;

   // Reserved payload bits and unused operand bits are deliberately ignored.
   assign unused_bits = ^s0_word;

   // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
   always_comb begin
      s1_next      = '0;
      s1_next.op   = s0_word[OP_HI:OP_LO];
      e            = s0_word[30:23];
      m24          = {1'b1, s0_word[F_MANT_W-1:0]};
      sh           = $signed(10'(e) - 10'd150 + 10'(FRAC_W));
      nsh          = 10'(-sh);
      rs           = (nsh > 10'd26) ? 6'd26 : nsh[5:0];
      rwide        = {m24, 26'b0} >> rs;
      lwide        = {40'b0, m24} << sh[5:0];
      xe           = {{(41-FX_W){s0_word[FX_W-1]}}, s0_word[FX_W-1:0]};
      xabs         = xe[40] ? -xe : xe;
      msb          = '0;
      for (int i = 0; i < 41; i++) begin
         if (xabs[i]) msb = 6'(i);
      end
      norm         = xabs << (6'd40 - msb);

      unique case (s1_next.op)
         OP_F2X: begin
            s1_next.sign = s0_word[31];
            if (e == F_EXP_ONES) begin
               s1_next.kind = (s0_word[F_MANT_W-1:0] == '0) ? K_SAT : K_NAN;
            end else if (e == 8'd0) begin
               s1_next.kind   = K_ZERO;
               s1_next.sticky = |s0_word[F_MANT_W-1:0];
            end else if (!sh[9]) begin
               s1_next.kind = K_F2X;
               s1_next.mag  = lwide[40:0];
               s1_next.ovf  = (sh > 10'sd40) || (|lwide[63:41]);
            end else begin
               s1_next.kind   = K_F2X;
               s1_next.mag    = {17'b0, rwide[49:26]};
               s1_next.guard  = rwide[25];
               s1_next.sticky = |rwide[24:0];
            end
         end
         OP_X2F: begin
            if (xabs == '0) begin
               s1_next.kind = K_ZERO;
            end else begin
               s1_next.kind   = K_X2F;
               s1_next.sign   = xe[40];
               s1_next.exp    = 8'(msb) - 8'(FRAC_W) + 8'(F_BIAS);
               s1_next.mag    = {17'b0, norm[40:17]};
               s1_next.guard  = norm[16];
               s1_next.sticky = |norm[15:0];
            end
         end
         default: s1_next.kind = K_RSVD;
      endcase
   end

   always_comb begin
      rnd    = s1.guard & (s1.sticky | s1.mag[0]);
      inex   = s1.guard | s1.sticky;
      mag_r  = {1'b0, s1.mag} + 42'(rnd);
      mant_r = {1'b0, s1.mag[23:0]} + 25'(rnd);
      res    = '0;
      sat    = 1'b0;
      unique case (s1.kind)
         K_F2X: begin
            if (s1.ovf || mag_r > (s1.sign ? NEG_LIM : POS_LIM)) begin
               res = fx_limit(FX_W, s1.sign);
               sat = 1'b1;
            end else begin
               res = s1.sign ? RES_W'(-mag_r) : RES_W'(mag_r);
            end
         end
         // A rounding carry leaves the low mantissa bits zero and bumps the exponent.
         K_X2F:  res = {8'b0, s1.sign, s1.exp + 8'(mant_r[24]), mant_r[F_MANT_W-1:0]};
         K_SAT: begin
            res = fx_limit(FX_W, s1.sign);
            sat = 1'b1;
         end
         K_NAN:  sat = 1'b1;
         K_RSVD: begin
            sat  = 1'b1;
            inex = 1'b1;
         end
         default: res = '0;
      endcase
   end

   assign out_word  = {s1.op, sat, inex, 4'b0, res};
   assign out_valid = v1;
   assign stage_cnt = {1'b0, v0} + {1'b0, v1};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else begin
         v0 <= in_valid;
         v1 <= v0;
      end
   end

   // NOTE: data registers and buffer storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (in_valid) s0_word <= in_word;
      if (v0)       s1      <= s1_next;
   end

endmodule

// File: rtl/fxfl_stream_conv.sv
// Streaming float32 <-> fixed converter between an upstream read FIFO and a downstream
// write FIFO; credit accounting keeps the output buffer from ever overflowing.
module fxfl_stream_conv
   import fxfl_pkg::*;
#(
   parameter int INT_W     = 16,
   parameter int FRAC_W    = 16,
   parameter int OUT_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [47:0]      datain,
   input  logic             empty,
   output logic             rden,
   output logic [47:0]      dataout,
   input  logic             full,
   output logic             wren,
   output logic             busy,
   output logic [CNT_W-1:0] sat_cnt
);

   localparam int AW = $clog2(OUT_DEPTH);

   logic             pend;
   logic [1:0]       stage_cnt;
   logic             res_valid;
   logic [47:0]      res_word;
   logic [47:0]      buf_mem [OUT_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [AW+1:0]    used;

   fxfl_cvt_pipe #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pend),
      .in_word   (datain),
      .out_valid (res_valid),
      .out_word  (res_word),
      .stage_cnt (stage_cnt)
   );

   assign wren = (count != '0) && !full;

   // The slot freed by this cycle's pop is re-credited at once, so the 4-cycle
   // pop-to-push loop sustains one word per cycle out of the buffer.
   assign used = (AW+2)'(count) + (AW+2)'(stage_cnt) + (AW+2)'(pend) - (AW+2)'(wren);
   assign rden = !rst && !empty && (used < (AW+2)'(OUT_DEPTH));

   assign dataout = (count != '0) ? buf_mem[rd_ptr] : '0;
   assign busy    = pend || (stage_cnt != 2'd0) || (count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend    <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         sat_cnt <= '0;
      end else begin
         pend <= rden;
         if (res_valid) wr_ptr <= wr_ptr + AW'(1);
         if (wren)      rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(res_valid) - (AW+1)'(wren);
         if (res_valid && res_word[SAT_BIT] && (sat_cnt != '1)) sat_cnt <= sat_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (res_valid) buf_mem[wr_ptr] <= res_word;
   end

endmodule

// File: tb/tb_fxfl_stream_conv.sv
// Scoreboard bench for fxfl_stream_conv: upstream FIFO model, in-order result checking.
module tb_fxfl_stream_conv;

   localparam int INT_W     = 16;
   localparam int FRAC_W    = 16;
   localparam int OUT_DEPTH = 4;
   localparam int CNT_W     = 16;

   localparam logic [47:0] VEC_IN [10] = '{
      48'h0000_3FC00000, 48'h0000_C0000000, 48'h0000_47800000, 48'h0000_7FC00000,
      48'h0000_37000000, 48'h0000_37400000, 48'h0000_37C00000, 48'h4000_00018000,
      48'h4000_00000001, 48'h4000_FFFFFFFF
   };
   localparam logic [47:0] VEC_EXP [10] = '{
      48'h000000018000, 48'h00FFFFFE0000, 48'h20007FFFFFFF, 48'h200000000000,
      48'h100000000000, 48'h100000000001, 48'h100000000002, 48'h40003FC00000,
      48'h400037800000, 48'h4000B7800000
   };

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [47:0]      datain = '0;
   logic             empty = 1'b1;
   logic             rden;
   logic [47:0]      dataout;
   logic             full = 1'b0;
   logic             wren;
   logic             busy;
   logic [CNT_W-1:0] sat_cnt;

   logic [47:0] up_q[$];
   logic [47:0] exp_q[$];
   int          rden_cyc[$];
   int          wren_cyc[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          outstanding = 0;
   logic [47:0] mon_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fxfl_stream_conv #(
      .INT_W     (INT_W),
      .FRAC_W    (FRAC_W),
      .OUT_DEPTH (OUT_DEPTH),
      .CNT_W     (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .datain  (datain),
      .empty   (empty),
      .rden    (rden),
      .dataout (dataout),
      .full    (full),
      .wren    (wren),
      .busy    (busy),
      .sat_cnt (sat_cnt)
   );

   // Upstream FIFO: a pop seen in cycle N presents its word throughout cycle N+1.
   initial begin : upstream
      logic pop;
      forever begin
         @(negedge clk);
         pop = rden;
         @(posedge clk);
         #1;
         if (pop && up_q.size() > 0) datain = up_q.pop_front();
         empty = (up_q.size() == 0);
      end
   end

   // Output monitor: scoreboard compare on every push, plus the buffer-overflow guard.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rden) begin
               outstanding++;
               rden_cyc.push_back(cyc);
            end
            if (wren) begin
               outstanding--;
               wren_cyc.push_back(cyc);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output: dataout=%h with no result owed", dataout);
               end else begin
                  mon_exp = exp_q.pop_front();
                  if (dataout !== mon_exp) begin
                     errors++;
                     $display("FAIL dataout: got %h expected %h", dataout, mon_exp);
                  end
               end
            end
            if (outstanding > OUT_DEPTH) begin
               checks++;
               errors++;
               $display("FAIL buffer_overflow: %0d words outstanding, limit %0d", outstanding, OUT_DEPTH);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic push_word(input logic [47:0] w, input logic [47:0] e);
      up_q.push_back(w);
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((up_q.size() != 0 || exp_q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (up_q.size() != 0 || exp_q.size() != 0 || busy) begin
         errors++;
         $display("FAIL %s_drain: %0d results still owed, busy=%0b", tag, exp_q.size(), busy);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks += 5;
      if (rden !== 1'b0)   begin errors++; $display("FAIL reset_rden: got %b expected 0", rden); end
      if (wren !== 1'b0)   begin errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
      if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (sat_cnt !== '0)  begin errors++; $display("FAIL reset_sat_cnt: got %0d expected 0", sat_cnt); end
      if (dataout !== '0)  begin errors++; $display("FAIL reset_dataout: got %h expected 0", dataout); end
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_latency();
      rden_cyc.delete();
      wren_cyc.delete();
      push_word(VEC_IN[0], VEC_EXP[0]);
      wait_drain("latency");
      checks++;
      if (rden_cyc.size() != 1 || wren_cyc.size() != 1) begin
         errors++;
         $display("FAIL latency_count: got %0d pops %0d pushes expected 1 and 1", rden_cyc.size(), wren_cyc.size());
      end else if (wren_cyc[0] - rden_cyc[0] != 4) begin
         errors++;
         $display("FAIL latency: got %0d cycles expected 4", wren_cyc[0] - rden_cyc[0]);
      end
      push_word(VEC_IN[1], VEC_EXP[1]);
      wait_drain("negative");
   endtask

   task automatic test_saturation();
      logic [47:0] w [4];
      logic [47:0] e [4];
      w = '{VEC_IN[2], VEC_IN[3], 48'h0000_FF800000, 48'h8000_00000000};
      e = '{VEC_EXP[2], VEC_EXP[3], 48'h20FF80000000, 48'hB00000000000};
      for (int i = 0; i < 4; i++) begin
         push_word(w[i], e[i]);
         wait_drain("saturation");
         checks++;
         if (sat_cnt !== CNT_W'(i + 1)) begin
            errors++;
            $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, sat_cnt, i + 1);
         end
      end
   endtask

   task automatic test_rounding();
      for (int i = 4; i < 7; i++) push_word(VEC_IN[i], VEC_EXP[i]);
      push_word(48'h0000_00000001, 48'h100000000000);
      push_word(48'h4000_7FFFFFFF, 48'h500047000000);
      wait_drain("rounding");
   endtask

   task automatic test_fix2float();
      for (int i = 7; i < 10; i++) push_word(VEC_IN[i], VEC_EXP[i]);
      push_word(48'h4000_80000000, 48'h4000C7000000);
      push_word(48'h4000_00000000, 48'h400000000000);
      wait_drain("fix2float");
   endtask

   task automatic test_back_to_back();
      @(posedge clk);
      #1 full = 1'b1;
      rden_cyc.delete();
      wren_cyc.delete();
      for (int i = 0; i < 10; i++) push_word(VEC_IN[i], VEC_EXP[i]);
      repeat (30) @(negedge clk);
      checks += 3;
      if (rden_cyc.size() != OUT_DEPTH) begin
         errors++;
         $display("FAIL backpressure_pops: got %0d expected %0d", rden_cyc.size(), OUT_DEPTH);
      end
      if (wren_cyc.size() != 0) begin
         errors++;
         $display("FAIL backpressure_push: got %0d pushes expected 0", wren_cyc.size());
      end
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_busy: got %b expected 1", busy);
      end
      @(posedge clk);
      #1 full = 1'b0;
      wait_drain("back_to_back");
      checks++;
      if (wren_cyc.size() != 10) begin
         errors++;
         $display("FAIL back_to_back_count: got %0d pushes expected 10", wren_cyc.size());
      end else if (wren_cyc[9] - wren_cyc[0] != 9) begin
         errors++;
         $display("FAIL back_to_back_span: got %0d cycles expected 9", wren_cyc[9] - wren_cyc[0]);
      end
   endtask

   task automatic test_reset_midstream();
      int n;
      rden_cyc.delete();
      for (int i = 0; i < 3; i++) push_word(VEC_IN[i], VEC_EXP[i]);
      n = 0;
      while (rden_cyc.size() < 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rden_cyc.size() < 3) begin
         errors++;
         $display("FAIL midstream_pops: got %0d expected 3", rden_cyc.size());
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks += 5;
      if (rden !== 1'b0)  begin errors++; $display("FAIL midreset_rden: got %b expected 0", rden); end
      if (wren !== 1'b0)  begin errors++; $display("FAIL midreset_wren: got %b expected 0", wren); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      if (sat_cnt !== '0) begin errors++; $display("FAIL midreset_sat_cnt: got %0d expected 0", sat_cnt); end
      if (dataout !== '0) begin errors++; $display("FAIL midreset_dataout: got %h expected 0", dataout); end
      up_q.delete();
      exp_q.delete();
      outstanding = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      wren_cyc.delete();
      push_word(VEC_IN[7], VEC_EXP[7]);
      wait_drain("after_reset");
      checks += 2;
      if (wren_cyc.size() != 1) begin
         errors++;
         $display("FAIL after_reset_count: got %0d pushes expected 1", wren_cyc.size());
      end
      if (sat_cnt !== '0) begin
         errors++;
         $display("FAIL after_reset_sat_cnt: got %0d expected 0", sat_cnt);
      end
   endtask

   initial begin : main
      test_reset();
      test_latency();
      test_saturation();
      test_rounding();
      test_fix2float();
      test_back_to_back();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
